// File: rtl/bmp_pkg.sv
// Shared bitmap geometry, cmpacc offset-word field map and aligner FSM states.
// Used by bmp_align and by the cmpacc-side logic that produces the offset word.
package bmp_pkg;

  localparam int ROWS  = 64;
  localparam int COLS  = 24;
  localparam int ROW_W = 6;

  // Offset word field positions (cmpacc result format)
  localparam int OFS_C_LSB     = 0;
  localparam int OFS_C_W       = 5;
  localparam int OFS_R_LSB     = 5;
  localparam int OFS_R_W       = 6;
  localparam int OFS_BLANK_BIT = 11;
  localparam int OFS_USED_W    = 12;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic               blank;
    logic [OFS_R_W-1:0] r;
    logic [OFS_C_W-1:0] c;
  } ofs_t;

  function automatic ofs_t unpack_ofs(input logic [OFS_USED_W-1:0] w);
    ofs_t o;
    o.c     = w[OFS_C_LSB +: OFS_C_W];
    o.r     = w[OFS_R_LSB +: OFS_R_W];
    o.blank = w[OFS_BLANK_BIT];
    return o;
  endfunction

endpackage

// File: rtl/bmp_row_shift.sv
// Combinational 24-bit left shift with zero fill; forced zero on blank/pad rows or C >= COLS.
// No latency, no flow control.
module bmp_row_shift
  import bmp_pkg::*;
(
  input  logic [COLS-1:0]    row,
  input  logic [OFS_C_W-1:0] c,
  input  logic               zero,
  output logic [COLS-1:0]    shifted
);

  always_comb begin
    shifted = '0;
    if (!zero && (32'(c) < COLS)) begin
      shifted = row << c;
    end
  end

endmodule

// File: rtl/bmp_align.sv
// Normalizes a 64x24 bitmap by dropping C left columns and pushing rows down by R, one row per cycle.
// done pulses in the cycle after edge N+65 for wren at edge N; wren is ignored while a job is active.
module bmp_align
  import bmp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wren,
  input  logic [ROWS*COLS-1:0] bitmap,
  input  logic [15:0]          offset,
  output logic [ROWS*COLS-1:0] aligned,
  output logic                 busy,
  output logic                 done
);

  state_t               state, state_nxt;
  logic [ROWS*COLS-1:0] bmp_q;
  logic [ROWS*COLS-1:0] aligned_q;
  ofs_t                 ofs_q;
  logic [ROW_W-1:0]     row_cnt;
  logic                 done_q;
  logic                 load;
  logic                 row_wr;
  logic                 last_row;

  logic [ROW_W-1:0]     src_idx;
  logic [COLS-1:0]      src_row;
  logic                 row_zero;
  logic [COLS-1:0]      row_out;

  // Top nibble of the offset word is reserved on the cmpacc side.
  logic unused_ofs;
  assign unused_ofs = ^offset[15:OFS_USED_W];

  assign last_row = (row_cnt == ROW_W'(ROWS-1));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    row_wr    = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (wren) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        row_wr = 1'b1;
        busy   = 1'b1;
        if (last_row) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output row k takes source row k-R; rows above R are padding.
  always_comb begin
    src_idx  = row_cnt - ofs_q.r;
    row_zero = ofs_q.blank || (row_cnt < ofs_q.r);
    src_row  = bmp_q[(ROWS-1-int'(src_idx))*COLS +: COLS];
  end

  bmp_row_shift u_row_shift (
    .row     (src_row),
    .c       (ofs_q.c),
    .zero    (row_zero),
    .shifted (row_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bmp_q     <= '0;
      ofs_q     <= '0;
      row_cnt   <= '0;
      aligned_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == DONE);
      if (load) begin
        bmp_q   <= bitmap;
        ofs_q   <= unpack_ofs(offset[OFS_USED_W-1:0]);
        row_cnt <= '0;
      end else if (row_wr && !last_row) begin
        row_cnt <= row_cnt + ROW_W'(1);
      end
      if (row_wr) begin
        aligned_q[(ROWS-1-int'(row_cnt))*COLS +: COLS] <= row_out;
      end
    end
  end

  assign aligned = aligned_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bmp_align.sv
// Randomized and directed checks of bmp_align against a row-level reference model.
module tb_bmp_align;

  localparam int NR = 64;
  localparam int NC = 24;
  localparam int DONE_LAT = 65;

  logic            clk;
  logic            rst_n;
  logic            wren;
  logic [1535:0]   bitmap;
  logic [15:0]     offset;
  logic [1535:0]   aligned;
  logic            busy;
  logic            done;

  int checks = 0;
  int passed = 0;

  bmp_align dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wren    (wren),
    .bitmap  (bitmap),
    .offset  (offset),
    .aligned (aligned),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs === expv) passed++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
  endtask

  function automatic logic [23:0] get_row(input logic [1535:0] v, input int i);
    return v[(NR-1-i)*NC +: NC];
  endfunction

  // Reference: image moves down R rows and left C columns; blank wipes it.
  function automatic logic [1535:0] model(input logic [1535:0] bm, input logic [15:0] ofs);
    logic [1535:0] res;
    int r, c;
    logic [47:0] wide;
    res = '0;
    c = int'(ofs[4:0]);
    r = int'(ofs[10:5]);
    if (!ofs[11]) begin
      for (int k = 0; k < NR; k++) begin
        if (k >= r && c < NC) begin
          wide = {24'h0, get_row(bm, k - r)} * (48'd1 << c);
          res[(NR-1-k)*NC +: NC] = wide[23:0];
        end
      end
    end
    return res;
  endfunction

  function automatic logic [1535:0] rand_bm();
    logic [1535:0] v;
    for (int i = 0; i < 48; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_rows(input string name, input logic [1535:0] expv);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s_row%0d", name, i), 32'(get_row(aligned, i)), 32'(get_row(expv, i)));
  endtask

  // guard_cyc: RUN cycle at which a stray wren with guard_bm is driven (0 = none).
  // abort_cyc: RUN cycle at which reset is pulsed (0 = none).
  task automatic run_job(input string name, input logic [1535:0] bm, input logic [15:0] ofs,
                         input int guard_cyc, input logic [1535:0] guard_bm, input int abort_cyc);
    logic [1535:0] expv;
    int lat;
    int pulses;
    expv = model(bm, ofs);
    lat = -1;
    pulses = 0;
    @(negedge clk);
    bitmap = bm;
    offset = ofs;
    wren   = 1'b1;
    @(negedge clk);
    wren = 1'b0;
    chk({name, "_busy_start"}, 32'(busy), 32'd1);
    for (int cyc = 1; cyc <= 90; cyc++) begin
      @(negedge clk);
      wren = 1'b0;
      if (cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        chk({name, "_abort_busy"}, 32'(busy), 32'd0);
        chk({name, "_abort_done"}, 32'(done), 32'd0);
        chk({name, "_abort_aligned"}, 32'(|aligned), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (cyc == guard_cyc) begin
        bitmap = guard_bm;
        offset = 16'h0003;
        wren   = 1'b1;
      end
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = cyc;
          chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
        end
      end
    end
    chk({name, "_done_lat"}, 32'(lat), 32'(DONE_LAT));
    chk({name, "_done_pulses"}, 32'(pulses), 32'd1);
    check_rows(name, expv);
  endtask

  initial begin
    logic [1535:0] bm;
    rst_n  = 1'b0;
    wren   = 1'b0;
    bitmap = '0;
    offset = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aligned", 32'(|aligned), 32'd0);
    rst_n = 1'b1;

    run_job("identity", rand_bm(), 16'h0000, 0, '0, 0);

    bm = '0;
    for (int i = 0; i < NR; i++)
      if (i == 3 || i == 4 || (i >= 7 && i <= 60)) bm[(NR-1-i)*NC +: NC] = 24'h3fffff;
    run_job("margin", bm, 16'h0042, 0, '0, 0);
    chk("margin_row5", 32'(get_row(aligned, 5)), 32'h00fffffc);
    chk("margin_row63", 32'(get_row(aligned, 63)), 32'h0);

    run_job("blank", {1536{1'b1}}, 16'h0800, 0, '0, 0);
    run_job("c24", rand_bm(), 16'h0018, 0, '0, 0);

    bm = rand_bm();
    bm[1535 -: 24] = 24'h800001;
    run_job("r63", bm, 16'ha7e0, 0, '0, 0);
    chk("r63_row63", 32'(get_row(aligned, 63)), 32'h00800001);

    run_job("guard", rand_bm(), 16'h0063, 10, rand_bm(), 0);
    run_job("abort", rand_bm(), 16'h0025, 0, '0, 30);
    run_job("post_abort", rand_bm(), 16'h0085, 0, '0, 0);

    for (int j = 0; j < 4; j++)
      run_job($sformatf("rnd%0d", j), rand_bm(), 16'($urandom) & 16'hf7ff, 0, '0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
